// File: rtl/inv_deglitch_pkg.sv
// Shared helpers for the inverting deglitch bank: parameter legality and threshold selection.
// Latency: none, compile-time and combinational helpers only.
// Backpressure: not applicable.
package inv_deglitch_pkg;

  // True when the bank parameters describe a buildable filter: at least two
  // synchroniser stages and both thresholds in 1..2^cnt_w, so the counter,
  // which only ever reaches threshold-1, can never wrap.
  function automatic bit params_legal(input int sync_stages,
                                      input int cnt_w,
                                      input int rise_cycles,
                                      input int fall_cycles);
    int max_thr;
    max_thr = 1 << cnt_w;
    return (sync_stages >= 2) &&
           (rise_cycles >= 1) && (rise_cycles <= max_thr) &&
           (fall_cycles >= 1) && (fall_cycles <= max_thr);
  endfunction

  // The synchronised sample picks the threshold: high means a rising
  // candidate, low means a falling candidate.
  function automatic int thresh_sel(input logic s,
                                    input int   rise_cycles,
                                    input int   fall_cycles);
    return s ? rise_cycles : fall_cycles;
  endfunction

endpackage

// File: rtl/inv_deglitch_ch.sv
// One deglitch channel: synchroniser, mismatch counter and filtered-state register.
// Latency: SYNC_STAGES + threshold cycles from a stable input change to f/chg.
// Backpressure: none; freeze holds f and cnt while the synchroniser keeps shifting.
//
// Ports:
//   clk, rst  - block clock, asynchronous active-high reset
//   i_raw     - raw asynchronous input
//   freeze    - hold filtered state and counter, suppress chg
//   f         - filtered state (registered)
//   chg       - one-cycle pulse on the cycle f takes a new value
module inv_deglitch_ch
  import inv_deglitch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int RISE_CYCLES = 8,
  parameter int FALL_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  input  logic freeze,
  output logic f,
  output logic chg
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       thr_m1;
  logic                   f_q, f_d;
  logic                   chg_q, chg_d;
  logic                   s;

  assign s      = sync_q[SYNC_STAGES-1];
  // Threshold-1 always fits CNT_W bits because thresholds are at most 2^CNT_W.
  assign thr_m1 = CNT_W'(thresh_sel(s, RISE_CYCLES, FALL_CYCLES) - 1);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_raw};
    f_d    = f_q;
    cnt_d  = cnt_q;
    chg_d  = 1'b0;
    if (!freeze) begin
      if (s == f_q) begin
        cnt_d = '0;
      end else if (cnt_q >= thr_m1) begin
        // Mismatch has lasted a full threshold: accept the new level.
        f_d   = s;
        cnt_d = '0;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      f_q    <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      f_q    <= f_d;
      chg_q  <= chg_d;
    end
  end

  assign f   = f_q;
  assign chg = chg_q;

endmodule

// File: rtl/inv_deglitch_bank.sv
// Bank of N_CH synchronised, deglitched channels, each optionally inverted by INV_MASK.
// Latency: SYNC_STAGES + RISE_CYCLES/FALL_CYCLES cycles from input change to o/o_chg.
// Backpressure: none; freeze holds every channel's filtered state and counter.
//
// Ports:
//   CELCLK, CELRST  - block clock, asynchronous active-high reset
//   CELV, CELG, SUB - supply, ground and substrate pins, no functional effect
//   i               - raw asynchronous channel inputs
//   freeze          - hold all filtered states and counters
//   o               - filtered state XOR INV_MASK, straight from registers
//   o_chg           - one-cycle pulse per channel when o[n] changes
module inv_deglitch_bank
  import inv_deglitch_pkg::*;
#(
  parameter int              N_CH        = 4,
  parameter int              SYNC_STAGES = 2,
  parameter int              CNT_W       = 4,
  parameter int              RISE_CYCLES = 8,
  parameter int              FALL_CYCLES = 8,
  parameter logic [N_CH-1:0] INV_MASK    = '1
) (
  input  logic            CELCLK,
  input  logic            CELRST,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            SUB,
  input  logic [N_CH-1:0] i,
  input  logic            freeze,
  output logic [N_CH-1:0] o,
  output logic [N_CH-1:0] o_chg
);

  if (!params_legal(SYNC_STAGES, CNT_W, RISE_CYCLES, FALL_CYCLES)) begin : g_param_err
    $error("inv_deglitch_bank: SYNC_STAGES must be >= 2 and thresholds within 1..2^CNT_W");
  end

  // Physical pins only ride along to the netlist.
  logic unused_pins;
  assign unused_pins = CELV ^ CELG ^ SUB;

  logic [N_CH-1:0] f;

  for (genvar n = 0; n < N_CH; n++) begin : g_ch
    inv_deglitch_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RISE_CYCLES (RISE_CYCLES),
      .FALL_CYCLES (FALL_CYCLES)
    ) u_ch (
      .clk    (CELCLK),
      .rst    (CELRST),
      .i_raw  (i[n]),
      .freeze (freeze),
      .f      (f[n]),
      .chg    (o_chg[n])
    );
  end

  // XOR of flop outputs with a constant: resets to INV_MASK, no path from i.
  assign o = f ^ INV_MASK;

endmodule

// File: tb/tb_inv_deglitch_bank.sv
// Self-checking bench for inv_deglitch_bank: two instances (symmetric 8/8 and asymmetric 3/12).
// Latency: expected o/o_chg events are queued with their exact arrival cycle.
// Backpressure: not applicable.
module tb_inv_deglitch_bank;

  typedef struct packed {
    int         cyc;
    logic [3:0] o;
    logic [3:0] chg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       freeze_a = 1'b0;
  logic       freeze_b = 1'b0;
  logic [3:0] i_a = 4'b0000;
  logic [3:0] i_b = 4'b0000;
  logic [3:0] o_a, o_chg_a, o_b, o_chg_b;
  logic [3:0] prev_a, prev_b;
  logic       mon_en = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q_a[$];
  exp_t       q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_deglitch_bank #(
    .N_CH(4), .SYNC_STAGES(2), .CNT_W(4),
    .RISE_CYCLES(8), .FALL_CYCLES(8), .INV_MASK(4'b1011)
  ) u_dut_a (
    .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i_a), .freeze(freeze_a), .o(o_a), .o_chg(o_chg_a)
  );

  inv_deglitch_bank #(
    .N_CH(4), .SYNC_STAGES(2), .CNT_W(4),
    .RISE_CYCLES(3), .FALL_CYCLES(12), .INV_MASK(4'b1011)
  ) u_dut_b (
    .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i_b), .freeze(freeze_b), .o(o_b), .o_chg(o_chg_b)
  );

  // Scoreboard monitors: every o_chg pulse must match the head of the queue
  // in cycle, output value and pulse mask; o must never move without a pulse.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst) begin
      if (o_chg_a !== 4'b0000) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL unexpected_chg_a: cyc=%0d o=%b o_chg=%b, required no event", cyc, o_a, o_chg_a);
        end else begin
          e = q_a.pop_front();
          if (cyc !== e.cyc || o_a !== e.o || o_chg_a !== e.chg) begin
            errors++;
            $display("FAIL event_a: got cyc=%0d o=%b chg=%b, required cyc=%0d o=%b chg=%b",
                     cyc, o_a, o_chg_a, e.cyc, e.o, e.chg);
          end
        end
      end else if (o_a !== prev_a) begin
        checks++;
        errors++;
        $display("FAIL silent_change_a: cyc=%0d o=%b, required %b", cyc, o_a, prev_a);
      end
      if (o_chg_b !== 4'b0000) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL unexpected_chg_b: cyc=%0d o=%b o_chg=%b, required no event", cyc, o_b, o_chg_b);
        end else begin
          e = q_b.pop_front();
          if (cyc !== e.cyc || o_b !== e.o || o_chg_b !== e.chg) begin
            errors++;
            $display("FAIL event_b: got cyc=%0d o=%b chg=%b, required cyc=%0d o=%b chg=%b",
                     cyc, o_b, o_chg_b, e.cyc, e.o, e.chg);
          end
        end
      end else if (o_b !== prev_b) begin
        checks++;
        errors++;
        $display("FAIL silent_change_b: cyc=%0d o=%b, required %b", cyc, o_b, prev_b);
      end
    end
    prev_a = o_a;
    prev_b = o_b;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_a !== 4'b1011) begin errors++; $display("FAIL reset_o_a: got %b, required 1011", o_a); end
    checks++; if (o_chg_a !== 4'b0000) begin errors++; $display("FAIL reset_chg_a: got %b, required 0000", o_chg_a); end
    checks++; if (o_b !== 4'b1011) begin errors++; $display("FAIL reset_o_b: got %b, required 1011", o_b); end
    checks++; if (o_chg_b !== 4'b0000) begin errors++; $display("FAIL reset_chg_b: got %b, required 0000", o_chg_b); end
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_clean_edge();
    exp_t e;
    @(negedge clk);
    i_a[0] = 1'b1;
    e.cyc = cyc + 10; e.o = 4'b1010; e.chg = 4'b0001; q_a.push_back(e);
    repeat (9) @(negedge clk);
    checks++; if (o_a !== 4'b1011) begin errors++; $display("FAIL clean_early: got %b, required 1011", o_a); end
    @(negedge clk);
    checks++; if (o_a !== 4'b1010) begin errors++; $display("FAIL clean_o: got %b, required 1010", o_a); end
    checks++; if (o_chg_a !== 4'b0001) begin errors++; $display("FAIL clean_pulse: got %b, required 0001", o_chg_a); end
    @(negedge clk);
    checks++; if (o_chg_a !== 4'b0000) begin errors++; $display("FAIL clean_pulse_len: got %b, required 0000", o_chg_a); end
    repeat (3) @(negedge clk);
    checks++; if (q_a.size() !== 0) begin errors++; $display("FAIL clean_drain: %0d pending, required 0", q_a.size()); end
  endtask

  task automatic test_glitch();
    exp_t e;
    int   c0;
    @(negedge clk);
    i_a[1] = 1'b1;
    repeat (7) @(negedge clk);
    i_a[1] = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (o_a !== 4'b1010) begin errors++; $display("FAIL glitch7_o: got %b, required 1010", o_a); end
    @(negedge clk);
    c0 = cyc;
    i_a[1] = 1'b1;
    e.cyc = c0 + 10; e.o = 4'b1000; e.chg = 4'b0010; q_a.push_back(e);
    e.cyc = c0 + 18; e.o = 4'b1010; e.chg = 4'b0010; q_a.push_back(e);
    repeat (8) @(negedge clk);
    i_a[1] = 1'b0;
    repeat (14) @(negedge clk);
    checks++; if (q_a.size() !== 0) begin errors++; $display("FAIL glitch8_drain: %0d pending, required 0", q_a.size()); end
  endtask

  task automatic test_asym();
    exp_t e;
    @(negedge clk);
    i_b[0] = 1'b1;
    e.cyc = cyc + 5; e.o = 4'b1010; e.chg = 4'b0001; q_b.push_back(e);
    repeat (8) @(negedge clk);
    checks++; if (q_b.size() !== 0) begin errors++; $display("FAIL asym_rise: %0d pending, required 0", q_b.size()); end
    i_b[0] = 1'b0;
    e.cyc = cyc + 14; e.o = 4'b1011; e.chg = 4'b0001; q_b.push_back(e);
    repeat (13) @(negedge clk);
    checks++; if (o_b !== 4'b1010) begin errors++; $display("FAIL asym_fall_early: got %b, required 1010", o_b); end
    repeat (3) @(negedge clk);
    checks++; if (q_b.size() !== 0) begin errors++; $display("FAIL asym_fall: %0d pending, required 0", q_b.size()); end
    checks++; if (o_b !== 4'b1011) begin errors++; $display("FAIL asym_final: got %b, required 1011", o_b); end
  endtask

  task automatic test_freeze();
    exp_t e;
    int   c0;
    @(negedge clk);
    c0 = cyc;
    i_a[2] = 1'b1;
    // Four mismatch samples are counted before freeze lands.
    e.cyc = c0 + 16; e.o = 4'b1110; e.chg = 4'b0100; q_a.push_back(e);
    repeat (6) @(negedge clk);
    freeze_a = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (o_a !== 4'b1010) begin errors++; $display("FAIL freeze_hold[%0d]: got %b, required 1010", k, o_a); end
    end
    freeze_a = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (q_a.size() !== 0) begin errors++; $display("FAIL freeze_resume: %0d pending, required 0", q_a.size()); end
    i_a[2] = 1'b0;
    e.cyc = cyc + 10; e.o = 4'b1010; e.chg = 4'b0100; q_a.push_back(e);
    repeat (12) @(negedge clk);
    checks++; if (q_a.size() !== 0) begin errors++; $display("FAIL freeze_back: %0d pending, required 0", q_a.size()); end
  endtask

  task automatic test_parallel();
    exp_t e;
    @(negedge clk);
    i_a = 4'b1110;
    e.cyc = cyc + 10; e.o = 4'b0101; e.chg = 4'b1111; q_a.push_back(e);
    repeat (12) @(negedge clk);
    checks++; if (q_a.size() !== 0) begin errors++; $display("FAIL parallel_drain: %0d pending, required 0", q_a.size()); end
    checks++; if (o_a[2] !== 1'b1) begin errors++; $display("FAIL passthru_bit2: got %b, required 1", o_a[2]); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    @(negedge clk);
    i_a[3] = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    i_a = 4'b0000;
    #1;
    checks++; if (o_a !== 4'b1011) begin errors++; $display("FAIL async_rst_o: got %b, required 1011", o_a); end
    checks++; if (o_chg_a !== 4'b0000) begin errors++; $display("FAIL async_rst_chg: got %b, required 0000", o_chg_a); end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (o_a !== 4'b1011) begin errors++; $display("FAIL post_rst_idle: got %b, required 1011", o_a); end
    mon_en = 1'b1;
    @(negedge clk);
    i_a[0] = 1'b1;
    e.cyc = cyc + 10; e.o = 4'b1010; e.chg = 4'b0001; q_a.push_back(e);
    repeat (12) @(negedge clk);
    checks++; if (q_a.size() !== 0) begin errors++; $display("FAIL post_rst_edge: %0d pending, required 0", q_a.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_edge();
    test_glitch();
    test_asym();
    test_freeze();
    test_parallel();
    test_async_reset();
    repeat (2) @(negedge clk);
    checks++; if (q_a.size() !== 0 || q_b.size() !== 0) begin
      errors++; $display("FAIL final_drain: a=%0d b=%0d pending, required 0", q_a.size(), q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
